serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock, using a single full-subtractor cell with a registered borrow. It is the inverse-direction companion to the team's ripple full-adder datapath. It trades area for latency in the arithmetic blocks. A start/busy/done handshake lets a controller FSM issue operations and collect results.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a new subtraction; sampled on rising clk
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  borrow-in, captured when start is accepted
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse: diff/bout valid and newly updated
diff  output  WIDTH  result a - b - bin modulo 2^WIDTH
bout  output  1  final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Clock: one clock. Reset: asynchronous, active-low (reset_n); polarity and synchronicity fixed.
- Reset (reset_n=0, any time incl. mid-operation): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow and bit counter cleared. Any in-flight operation is abandoned and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1 at an edge, capture a, b, bin into internal regs. Counter=0. Go to RUN.
- RUN: busy=1. Each edge processes the current LSBs x=a_reg[0], y=b_reg[0] with borrow c:
  - d = x ^ y ^ c
  - c_next = (~x & y) | (~(x ^ y) & c)
  - d shifts into the MSB of the result shift register; a_reg and b_reg shift right; counter increments.
  - On the edge processing bit WIDTH-1: load diff from the completed shift register, set bout=c_next, and go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 at this edge: accepted as in IDLE, go to RUN (back-to-back operations allowed).
  - Otherwise: go to IDLE.
- Latency: start sampled at edge E0 gives done=1 in the cycle following edge E(WIDTH). Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands and bin are not re-sampled during RUN, so a/b/bin may change freely after acceptance.
- diff and bout change only at the transition into DONE, or on reset. They hold their value through IDLE and the following RUN until the next completion.
- done and busy are never high simultaneously. busy is registered (state-decoded), with no combinational path from start.
- Arithmetic is unsigned modulo 2^WIDTH. A signed overflow flag is out of scope.

Test Plan:
- WIDTH=4, reset_n pulsed low asynchronously (between edges) -> busy=0, done=0, diff=0, bout=0 immediately, before the next clk edge.
- a=9, b=3, bin=0, start 1 cycle -> busy for 4 cycles, done pulse on 5th cycle after start edge, diff=6, bout=0.
- a=3, b=9, bin=0 -> diff=10 (4'hA), bout=1. Then a=0, b=0, bin=1 -> diff=15, bout=1. Then a=15, b=15, bin=0 -> diff=0, bout=0.
- start held high continuously with a=7, b=2 -> completions every 5 cycles with diff=5, bout=0. start during RUN has no effect; changing a/b mid-RUN does not alter the result.
- Reset asserted on the 2nd RUN cycle of a=12, b=5 -> no done pulse, outputs 0. After release, new start with a=12, b=5 -> diff=7, bout=0.
- Exhaustive: all 512 (a, b, bin) combinations for WIDTH=4 compared against reference model {bout, diff} = {1'b0, a} - b - bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic x;
  logic y;
  logic d;
  logic c_next;
  logic accept;
  logic last_bit;

  assign x        = a_reg[0];
  assign y        = b_reg[0];
  assign d        = x ^ y ^ c;
  assign c_next   = (~x & y) | (~(x ^ y) & c);
  assign accept   = start && (state != RUN);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result regs only move on the completing edge so they hold through IDLE and the next RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      sr    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      sr    <= '0;
      c     <= bin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      sr    <= {d, sr[WIDTH-1:1]};
      c     <= c_next;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        diff <= {d, sr[WIDTH-1:1]};
        bout <= c_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       bin = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation: start pulsed for one cycle, operands scrambled after acceptance,
  // a stray start during RUN, then wait (bounded) for done.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                       output int lat, output int busy_cycles, output int overlap);
    @(negedge clk);
    a = ai; b = bi; bin = ci; start = 1'b1;
    lat = -1; busy_cycles = 0; overlap = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; a = ~ai; b = ~bi; bin = ~ci; end
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (busy && done) overlap++;
      if (busy) busy_cycles++;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    chk("done_seen", (lat > 0), 1);
    if (lat > 0) begin
      @(negedge clk);
      chk("done_single_pulse", done, 0);
    end
  endtask

  initial begin
    int lat, bc, ov, saw_done;
    logic [4:0] ref5;

    vecs[0] = '{4'd9,  4'd3, 1'b0, 4'd6,  1'b0};
    vecs[1] = '{4'd0,  4'd0, 1'b1, 4'd15, 1'b1};
    vecs[2] = '{4'd15, 4'd15,1'b0, 4'd0,  1'b0};
    vecs[3] = '{4'd12, 4'd5, 1'b0, 4'd7,  1'b0};
    vecs[4] = '{4'd3,  4'd9, 1'b0, 4'd10, 1'b1};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc, ov);
      chk("vec_diff", diff, vecs[i].exp_diff);
      chk("vec_bout", bout, vecs[i].exp_bout);
      chk("vec_latency", lat, 5);
      chk("vec_busy_cycles", bc, 4);
      chk("vec_busy_done_overlap", ov, 0);
    end

    // Asynchronous reset between edges clears outputs before any clock edge.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_diff", diff, 0);
    chk("async_rst_bout", bout, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // start held high: a completion every 5 cycles, mid-RUN operand changes ignored.
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 2) begin a = 4'd0; b = 4'd15; end
      if (k == 3) begin a = 4'd7; b = 4'd2; end
      chk("held_done", done, (k % 5 == 0));
      chk("held_busy", busy, (k % 5 != 0));
      if (k % 5 == 0) begin
        chk("held_diff", diff, 5);
        chk("held_bout", bout, 0);
      end
    end
    start = 1'b0;

    // Reset on the 2nd RUN cycle abandons the operation.
    @(negedge clk);
    a = 4'd12; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_diff", diff, 0);
    chk("midrun_rst_bout", bout, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    chk("midrun_no_done", saw_done, 0);
    chk("midrun_hold_diff", diff, 0);
    do_op(4'd12, 4'd5, 1'b0, lat, bc, ov);
    chk("after_rst_diff", diff, 7);
    chk("after_rst_bout", bout, 0);
    chk("after_rst_latency", lat, 5);

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          do_op(4'(ai), 4'(bi), 1'(ci), lat, bc, ov);
          ref5 = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - {4'd0, 1'(ci)};
          chk("exh_diff", diff, ref5[3:0]);
          chk("exh_bout", bout, ref5[4]);
          chk("exh_latency", lat, 5);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
